// File: rtl/mecmouse_pkg.sv
// Shared definitions for the mecmouse host: state encoding, PS/2 packet
// bit positions and the 3-bit delta code helpers (also usable by benches).
package mecmouse_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RST_PH  = 4'd1,
    ST_SX_J2   = 4'd2,
    ST_GX      = 4'd3,
    ST_SX_J1   = 4'd4,
    ST_GY_J2   = 4'd5,
    ST_GY      = 4'd6,
    ST_SY_J1   = 4'd7,
    ST_PUBLISH = 4'd8
  } mecmouse_state_e;

  // PS/2 packet layout on ps2_mouse_o
  localparam int PS2_STROBE = 24;
  localparam int PS2_DY_MSB = 23;
  localparam int PS2_DY_LSB = 16;
  localparam int PS2_DX_MSB = 15;
  localparam int PS2_DX_LSB = 8;
  localparam int PS2_BIT_L  = 0;
  localparam int PS2_BIT_R  = 1;
  localparam int PS2_BIT_1  = 3;
  localparam int PS2_BIT_XS = 4;
  localparam int PS2_BIT_YS = 5;
  localparam logic [24:0] PS2_RESET = 25'h0000008;

  // Device code d carries value (d+1) mod 8 read as a signed 3-bit number.
  function automatic logic signed [2:0] mm_decode(input logic [2:0] code);
    logic [2:0] raw;
    raw = code + 3'd1;
    return $signed(raw);
  endfunction

  // Inverse of mm_decode: code = (value - 1) mod 8.
  function automatic logic [2:0] mm_encode(input logic signed [2:0] value);
    logic [2:0] raw;
    raw = value;
    return raw - 3'd1;
  endfunction

endpackage

// File: rtl/mecmouse_phase_timer.sv
// Loadable down-counter. done is high while the count sits at zero, so a
// load of N-1 on entry to a phase gives a done on the N-th cycle; feeding
// done back into load makes it a free-running period tick.
module mecmouse_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/mecmouse_host.sv
// Mecmouse host: sequences the two joystick selects to read X and Y deltas
// from a Mecmouse device and publishes them as a PS/2-style packet with a
// toggle strobe. Optional feature macro: MECMOUSE_HOST_AUTO_EN adds a
// free-running POLL_PERIOD poll trigger alongside start.
module mecmouse_host
  import mecmouse_pkg::*;
#(
  parameter int SETTLE      = 8,
  parameter int GAP         = 4,
  parameter int POLL_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  mecmouse_i,
  output logic        j1_s,
  output logic        j2_s,
  output logic [24:0] ps2_mouse_o,
  output logic        busy
);

  localparam logic [3:0] IDLE    = ST_IDLE;
  localparam logic [3:0] RST_PH  = ST_RST_PH;
  localparam logic [3:0] SX_J2   = ST_SX_J2;
  localparam logic [3:0] GX      = ST_GX;
  localparam logic [3:0] SX_J1   = ST_SX_J1;
  localparam logic [3:0] GY_J2   = ST_GY_J2;
  localparam logic [3:0] GY      = ST_GY;
  localparam logic [3:0] SY_J1   = ST_SY_J1;
  localparam logic [3:0] PUBLISH = ST_PUBLISH;

  localparam int PH_MAX = (SETTLE > GAP) ? SETTLE : GAP;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SETTLE_LD = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0] GAP_LD    = PH_W'(GAP - 1);

  logic [3:0]      state_reg, state_next;
  logic            phase_load, phase_done;
  logic [PH_W-1:0] phase_value;
  logic            sample_x, sample_y, publish;
  logic            trigger;

  logic [2:0]  x_code_reg, y_code_reg;
  logic [1:0]  x_btn_reg;    // {bit4, bit0} as sampled in the X phase
  logic [1:0]  last_lr_reg;  // {R, L} of the last published packet
  logic [24:0] ps2_reg, packet_next;

  logic signed [2:0] vx, vy;
  logic [7:0]        dx, dy;
  logic [1:0]        lr_now;
  logic              report;

  mecmouse_phase_timer #(.WIDTH(PH_W)) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .load  (phase_load),
    .value (phase_value),
    .done  (phase_done)
  );

`ifdef MECMOUSE_HOST_AUTO_EN
  localparam int POLL_W = $clog2(POLL_PERIOD + 1);
  localparam logic [POLL_W-1:0] POLL_LD = POLL_W'(POLL_PERIOD - 1);

  logic poll_tick;
  logic pending_reg;

  mecmouse_phase_timer #(.WIDTH(POLL_W)) u_poll_timer (
    .clk   (clk),
    .reset (reset),
    .load  (poll_tick),
    .value (POLL_LD),
    .done  (poll_tick)
  );

  // Remember one auto tick that lands while a poll is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      pending_reg <= 1'b0;
    end else if (poll_tick) begin
      pending_reg <= 1'b1;
    end
  end

  assign trigger = (state_reg == IDLE) && (start || poll_tick || pending_reg);
`else
  assign trigger = (state_reg == IDLE) && start;
`endif

  // Phase sequencer: each phase loads its length into the timer on entry.
  always_comb begin
    state_next  = state_reg;
    phase_load  = 1'b0;
    phase_value = GAP_LD;
    sample_x    = 1'b0;
    sample_y    = 1'b0;
    publish     = 1'b0;
    case (state_reg)
      IDLE: if (trigger) begin
        state_next = RST_PH;
        phase_load = 1'b1;
      end
      RST_PH: if (phase_done) begin
        state_next  = SX_J2;
        phase_load  = 1'b1;
        phase_value = SETTLE_LD;
      end
      SX_J2: if (phase_done) begin
        sample_x   = 1'b1;
        state_next = GX;
        phase_load = 1'b1;
      end
      GX: if (phase_done) begin
        state_next  = SX_J1;
        phase_load  = 1'b1;
        phase_value = SETTLE_LD;
      end
      SX_J1: if (phase_done) begin
        state_next  = GY_J2;
        phase_load  = 1'b1;
        phase_value = SETTLE_LD;
      end
      GY_J2: if (phase_done) begin
        sample_y   = 1'b1;
        state_next = GY;
        phase_load = 1'b1;
      end
      GY: if (phase_done) begin
        state_next  = SY_J1;
        phase_load  = 1'b1;
        phase_value = SETTLE_LD;
      end
      SY_J1: if (phase_done) begin
        state_next = PUBLISH;
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the device return bits on the last cycle of each sample phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_code_reg <= 3'd0;
      x_btn_reg  <= 2'd0;
      y_code_reg <= 3'd0;
    end else begin
      if (sample_x) begin
        x_code_reg <= mecmouse_i[3:1];
        x_btn_reg  <= {mecmouse_i[4], mecmouse_i[0]};
      end
      if (sample_y) begin
        y_code_reg <= mecmouse_i[3:1];
      end
    end
  end

  assign vx     = mm_decode(x_code_reg);
  assign vy     = mm_decode(y_code_reg);
  assign dx     = {{5{vx[2]}}, vx};
  assign dy     = 8'd0 - {{5{vy[2]}}, vy};   // device Y grows downward
  assign lr_now = {~x_btn_reg[1], ~x_btn_reg[0]};
  assign report = (dx != 8'd0) || (dy != 8'd0) || (lr_now != last_lr_reg);

  // Assemble the candidate packet with the strobe already flipped.
  always_comb begin
    packet_next                        = ps2_reg;
    packet_next[PS2_STROBE]            = ~ps2_reg[PS2_STROBE];
    packet_next[PS2_DY_MSB:PS2_DY_LSB] = dy;
    packet_next[PS2_DX_MSB:PS2_DX_LSB] = dx;
    packet_next[7:0]                   = 8'h00;
    packet_next[PS2_BIT_L]             = lr_now[0];
    packet_next[PS2_BIT_R]             = lr_now[1];
    packet_next[PS2_BIT_1]             = 1'b1;
    packet_next[PS2_BIT_XS]            = dx[7];
    packet_next[PS2_BIT_YS]            = dy[7];
  end

  // Publish only when something moved or the buttons changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_reg     <= PS2_RESET;
      last_lr_reg <= 2'd0;
    end else if (publish && report) begin
      ps2_reg     <= packet_next;
      last_lr_reg <= lr_now;
    end
  end

  assign j1_s        = (state_reg == SX_J1) || (state_reg == SY_J1);
  assign j2_s        = (state_reg == SX_J2) || (state_reg == GY_J2);
  assign busy        = (state_reg != IDLE);
  assign ps2_mouse_o = ps2_reg;

endmodule

// File: tb/tb_mecmouse_host.sv
// Bench for mecmouse_host: a behavioural Mecmouse device drives the return
// bits, a reference model predicts each published packet and its cycle,
// and a monitor compares every strobe toggle against the expected queue.
module tb_mecmouse_host;

  localparam int SETTLE = 8;
  localparam int GAP    = 4;
`ifdef MECMOUSE_HOST_AUTO_EN
  localparam int POLL = 100;
`else
  localparam int POLL = 50000;
`endif
  localparam int LAT = 3*GAP + 4*SETTLE + 2;

  typedef struct {
    logic [24:0] pkt;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  mecmouse_i;
  logic        j1_s, j2_s, busy;
  logic [24:0] ps2_mouse_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // device state
  int   dev_ax = 0, dev_ay = 0;
  logic dev_phase_y = 1'b0;
  logic btn_l = 1'b0, btn_r = 1'b0;
  logic force_en = 1'b0;
  logic [4:0] force_val = 5'd0;
  logic j1_q = 1'b0, j2_q = 1'b0;

  // reference model state
  exp_t exp_q[$];
  int   mdl_ax = 0, mdl_ay = 0;
  logic [1:0] mdl_lr = 2'b00;
  logic mdl_strobe = 1'b0;

  mecmouse_host #(.SETTLE(SETTLE), .GAP(GAP), .POLL_PERIOD(POLL)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mecmouse_i  (mecmouse_i),
    .j1_s        (j1_s),
    .j2_s        (j2_s),
    .ps2_mouse_o (ps2_mouse_o),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic int clamp3(int v);
    if (v > 3) return 3;
    if (v < -4) return -4;
    return v;
  endfunction

  function automatic logic [2:0] enc(int v);
    int e;
    e = (v + 7) % 8;
    return 3'(e);
  endfunction

  function automatic int dec(logic [2:0] d);
    int v;
    v = (int'(d) + 1) % 8;
    if (v > 3) v = v - 8;
    return v;
  endfunction

  // Device: reports the clamped pending delta of its current axis.
  assign mecmouse_i = force_en ? force_val
                    : {~btn_r, enc(clamp3(dev_phase_y ? dev_ay : dev_ax)), ~btn_l};

  // Device: j1 rising flips the axis, j2 falling consumes the reported delta.
  initial begin
    forever begin
      @(negedge clk);
      if (j1_s && !j1_q) dev_phase_y = ~dev_phase_y;
      if (!j2_s && j2_q) begin
        if (dev_phase_y) dev_ay = dev_ay - clamp3(dev_ay);
        else             dev_ax = dev_ax - clamp3(dev_ax);
      end
      j1_q = j1_s;
      j2_q = j2_s;
    end
  end

  // Monitor: select exclusivity every cycle, and every strobe toggle
  // against the scoreboard (packet contents and arrival cycle).
  initial begin
    logic prev_strobe;
    logic resync;
    exp_t e;
    prev_strobe = 1'b0;
    resync      = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        resync = 1'b1;
      end else if (resync) begin
        resync = 1'b0;
      end else begin
        if (j1_s || j2_s) begin
          total = total + 1;
          if (j1_s && j2_s) begin
            bad = bad + 1;
            $display("FAIL select_overlap: got j1_s=1 j2_s=1 at cycle %0d, want not both", cyc);
          end
        end
        if (ps2_mouse_o[24] != prev_strobe) begin
          total = total + 1;
          if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_strobe: got packet %h at cycle %0d, want no toggle", ps2_mouse_o, cyc);
          end else begin
            e = exp_q.pop_front();
            if (ps2_mouse_o !== e.pkt) begin
              bad = bad + 1;
              $display("FAIL packet: got %h want %h", ps2_mouse_o, e.pkt);
            end
            total = total + 1;
            if (cyc != e.at) begin
              bad = bad + 1;
              $display("FAIL latency: got cycle %0d want cycle %0d", cyc, e.at);
            end
            $display("packet %h at cycle %0d", ps2_mouse_o, cyc);
          end
        end
      end
      prev_strobe = ps2_mouse_o[24];
    end
  end

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic inject(input int mx, input int my);
    // my is the host-visible dy; the device counts Y the other way round
    dev_ax = dev_ax + mx;
    mdl_ax = mdl_ax + mx;
    dev_ay = dev_ay - my;
    mdl_ay = mdl_ay - my;
  endtask

  // Reference model of one complete poll issued at cycle t.
  task automatic model_poll(input int t);
    int vx, vy, dxi, dyi;
    logic l, r;
    logic [7:0] dx8, dy8;
    if (force_en) begin
      vx = dec(force_val[3:1]);
      vy = vx;
      l  = ~force_val[0];
      r  = ~force_val[4];
    end else begin
      vx = clamp3(mdl_ax);
      mdl_ax = mdl_ax - vx;
      vy = clamp3(mdl_ay);
      mdl_ay = mdl_ay - vy;
      l = btn_l;
      r = btn_r;
    end
    dxi = vx;
    dyi = -vy;
    if (dxi != 0 || dyi != 0 || {r, l} != mdl_lr) begin
      exp_t e;
      mdl_strobe = ~mdl_strobe;
      mdl_lr = {r, l};
      dx8 = 8'(dxi);
      dy8 = 8'(dyi);
      e.pkt = {mdl_strobe, dy8, dx8, 2'b00, (dyi < 0), (dxi < 0), 1'b1, 1'b0, r, l};
      e.at  = t + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    if (busy) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL wait_idle: got busy=1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic issue(output int t);
    @(posedge clk); #1;
    start = 1'b1;
    t = cyc;
    model_poll(t);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {24'd0, busy}, 25'd1);
  endtask

  task automatic poll();
    int t;
    wait_idle();
    issue(t);
    wait_idle();
  endtask

  initial begin
    int t;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_j1", {24'd0, j1_s}, 25'd0);
    chk("reset_j2", {24'd0, j2_s}, 25'd0);
    chk("reset_busy", {24'd0, busy}, 25'd0);
    chk("reset_ps2", ps2_mouse_o, 25'h0000008);

`ifdef MECMOUSE_HOST_AUTO_EN
    begin
      int last_rise, rises;
      logic pb;
      last_rise = -1;
      rises = 0;
      pb = busy;
      repeat (620) begin
        @(posedge clk); #1;
        if (busy && !pb) begin
          if (last_rise >= 0) chk("auto_period", 25'(cyc - last_rise), 25'd100);
          last_rise = cyc;
          rises = rises + 1;
        end
        pb = busy;
      end
      total = total + 1;
      if (rises < 5) begin
        bad = bad + 1;
        $display("FAIL auto_polls: got %0d polls want at least 5", rises);
      end
    end
`else
    // +5 in X arrives as +3 then +2
    inject(5, 0);
    poll();
    chk("x5_first", ps2_mouse_o, {1'b1, 8'h00, 8'h03, 8'h08});
    poll();
    chk("x5_second", ps2_mouse_o, {1'b0, 8'h00, 8'h02, 8'h08});

    // -9 in X arrives as -4, -4, -1, then nothing to report
    inject(-9, 0);
    poll();
    chk("xm9_first", ps2_mouse_o, {1'b1, 8'h00, 8'hFC, 8'h18});
    poll();
    chk("xm9_second", ps2_mouse_o, {1'b0, 8'h00, 8'hFC, 8'h18});
    poll();
    chk("xm9_third", ps2_mouse_o, {1'b1, 8'h00, 8'hFF, 8'h18});
    poll();
    chk("xm9_idle", ps2_mouse_o, {1'b1, 8'h00, 8'hFF, 8'h18});

    // Y direction and sign bit
    inject(0, 2);
    poll();
    chk("dy_plus2", ps2_mouse_o, {1'b0, 8'h02, 8'h00, 8'h08});
    inject(0, -3);
    poll();
    chk("dy_minus3", ps2_mouse_o, {1'b1, 8'hFD, 8'h00, 8'h28});

    // forced return bits: left pressed, code 7 (zero motion) on both axes
    force_en  = 1'b1;
    force_val = 5'b11110;
    poll();
    chk("forced_left", ps2_mouse_o, {1'b0, 8'h00, 8'h00, 8'h09});
    poll();
    chk("forced_repeat", ps2_mouse_o, {1'b0, 8'h00, 8'h00, 8'h09});
    force_en = 1'b0;

    // a second start while busy must be ignored
    wait_idle();
    issue(t);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // reset in the middle of the Y sample phase
    inject(2, 1);
    issue(t);
    repeat (2*GAP + 2*SETTLE + 1) @(posedge clk);
    #1;
    chk("in_gy_j2", {23'd0, j1_s, j2_s}, 25'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_j1", {24'd0, j1_s}, 25'd0);
    chk("midreset_j2", {24'd0, j2_s}, 25'd0);
    chk("midreset_busy", {24'd0, busy}, 25'd0);
    chk("midreset_ps2", ps2_mouse_o, 25'h0000008);
    exp_q.delete();
    mdl_strobe  = 1'b0;
    mdl_lr      = 2'b00;
    mdl_ax      = 0;
    mdl_ay      = 0;
    dev_ax      = 0;
    dev_ay      = 0;
    dev_phase_y = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // randomized motion, buttons and occasional forced return bits
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(5) == 0) begin
        dev_ax = 0; dev_ay = 0; mdl_ax = 0; mdl_ay = 0;
        force_en  = 1'b1;
        force_val = 5'($urandom_range(31));
      end else begin
        force_en = 1'b0;
        if ($urandom_range(2) != 0)
          inject(int'($urandom_range(20)) - 10, int'($urandom_range(20)) - 10);
        if ($urandom_range(3) == 0) begin
          btn_l = 1'($urandom_range(1));
          btn_r = 1'($urandom_range(1));
        end
      end
      poll();
    end
    force_en = 1'b0;
`endif

    repeat (5) @(posedge clk);
    #1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL missing_packets: got %0d still queued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
